// File: rtl/pheap_level_stage_pkg.sv
// Shared types for the pipelined heap level stages: token ops, stage FSM
// states, heap entry layout and the entry key compare.
package pheap_level_stage_pkg;

    localparam int KEY_W  = 16;
    localparam int DATA_W = 15;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_INSERT = 2'd1,
        OP_SIFT   = 2'd2
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_OWN,
        ST_CMP_INS,
        ST_WAIT_CHD,
        ST_RD_C0,
        ST_RD_C1,
        ST_CMP_SIFT,
        ST_FWD
    } stage_state_t;

    typedef struct packed {
        logic              valid;
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] data;
    } entry_t;

    // An empty slot behaves as +infinity, so it never wins a compare.
    function automatic logic key_lt(input entry_t a, input entry_t b);
        return a.valid && (!b.valid || (a.key < b.key));
    endfunction

endpackage

// File: rtl/pheap_level_stage_min2.sv
// Combinational minimum of two heap entries; 'a' wins ties, sel=1 picks 'b'.
module pheap_min2
    import pheap_level_stage_pkg::*;
(
    input  entry_t a,
    input  entry_t b,
    output entry_t m,
    output logic   sel
);

    always_comb begin
        sel = key_lt(b, a);
        m   = sel ? b : a;
    end

endmodule

// File: rtl/pheap_level_stage.sv
// One level of the pipelined heap: insert / sift-down step on its own RAM,
// reads the child RAM and forwards tokens. Optional PHEAP_LEVEL_STATS_EN adds op counters.
//
// state     | meaning
// ----------|----------------------------------------------------------
// IDLE      | ready for a token; own_addr follows in_addr
// RD_OWN    | own RAM read of token node in flight
// CMP_INS   | compare insert token against node, write and/or forward
// WAIT_CHD  | sift waits until the child level is not writing its RAM
// RD_C0     | read left child
// RD_C1     | read right child, capture left child
// CMP_SIFT  | pick smaller child, write own node, maybe forward sift
// FWD       | hold forwarded token until the child stage accepts
module pheap_level_stage
    import pheap_level_stage_pkg::*;
#(
    parameter int LEVEL     = 2,
    parameter int MAX_LEVEL = 8,
    parameter int PATH_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  op_t               in_op,
    input  logic [LEVEL-2:0]  in_addr,
    input  entry_t            in_entry,
    input  logic [PATH_W-1:0] in_path,
    output logic              out_valid,
    input  logic              out_ready,
    output op_t               out_op,
    output logic [LEVEL-1:0]  out_addr,
    output entry_t            out_entry,
    output logic [PATH_W-1:0] out_path,
    output logic              own_we,
    output logic [LEVEL-2:0]  own_addr,
    output entry_t            own_wdata,
    input  entry_t            own_q,
    output logic [LEVEL-1:0]  chd_addr,
    input  entry_t            chd_q,
    input  logic              chd_idle,
    output logic              idle,
`ifdef PHEAP_LEVEL_STATS_EN
    output logic [15:0]       stat_ins,
    output logic [15:0]       stat_sift,
    output logic [15:0]       stat_ovf,
`endif
    output logic              overflow
);

    localparam bit IS_LEAF = (LEVEL >= MAX_LEVEL);

    stage_state_t      state, state_nx;
    logic              run_q;
    logic [LEVEL-2:0]  tok_addr;
    entry_t            tok_entry;
    logic [PATH_W-1:0] tok_path;
    entry_t            c0_q;
    op_t               fwd_op;
    logic [LEVEL-1:0]  fwd_addr;
    entry_t            fwd_entry;
    logic [PATH_W-1:0] fwd_path;
    logic              overflow_q;

    entry_t c0_in, c1_in, m_entry;
    logic   m_sel, ins_lt, sift_down, accept, ovf_evt;

    // A leaf has no children: both compare as empty.
    assign c0_in = IS_LEAF ? '0 : c0_q;
    assign c1_in = IS_LEAF ? '0 : chd_q;

    pheap_min2 u_min2 (
        .a   (c0_in),
        .b   (c1_in),
        .m   (m_entry),
        .sel (m_sel)
    );

    assign ins_lt    = key_lt(tok_entry, own_q);
    assign sift_down = m_entry.valid && key_lt(m_entry, tok_entry);
    assign accept    = in_valid && in_ready;
    assign ovf_evt   = (state == ST_CMP_INS) && IS_LEAF && own_q.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            run_q <= 1'b0;
        end else begin
            state <= state_nx;
            run_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (in_op == OP_INSERT)    state_nx = ST_RD_OWN;
                    else if (in_op == OP_SIFT) state_nx = ST_WAIT_CHD;
                end
            end
            ST_RD_OWN:   state_nx = ST_CMP_INS;
            ST_CMP_INS:  state_nx = (!own_q.valid || IS_LEAF) ? ST_IDLE : ST_FWD;
            ST_WAIT_CHD: begin
                if (IS_LEAF)       state_nx = ST_CMP_SIFT;
                else if (chd_idle) state_nx = ST_RD_C0;
            end
            ST_RD_C0:    state_nx = ST_RD_C1;
            ST_RD_C1:    state_nx = ST_CMP_SIFT;
            ST_CMP_SIFT: state_nx = (sift_down && !IS_LEAF) ? ST_FWD : ST_IDLE;
            ST_FWD:      if (out_ready) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        idle      = 1'b0;
        out_valid = 1'b0;
        own_we    = 1'b0;
        own_wdata = '0;
        own_addr  = tok_addr;
        chd_addr  = '0;
        case (state)
            ST_IDLE: begin
                in_ready = run_q;
                idle     = 1'b1;
                own_addr = run_q ? in_addr : '0;
            end
            ST_CMP_INS: begin
                if (!own_q.valid || ins_lt) begin
                    own_we    = 1'b1;
                    own_wdata = tok_entry;
                end
            end
            ST_RD_C0: chd_addr = {tok_addr, 1'b0};
            ST_RD_C1: chd_addr = {tok_addr, 1'b1};
            ST_CMP_SIFT: begin
                own_we    = 1'b1;
                own_wdata = sift_down ? m_entry : tok_entry;
            end
            ST_FWD: out_valid = !IS_LEAF;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_addr   <= '0;
            tok_entry  <= '0;
            tok_path   <= '0;
            c0_q       <= '0;
            fwd_op     <= OP_NOP;
            fwd_addr   <= '0;
            fwd_entry  <= '0;
            fwd_path   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                tok_addr  <= in_addr;
                tok_entry <= in_entry;
                tok_path  <= in_path;
            end
            if (state == ST_RD_C1) c0_q <= chd_q;
            if (state == ST_CMP_INS && own_q.valid && !IS_LEAF) begin
                fwd_op    <= OP_INSERT;
                fwd_addr  <= {tok_addr, tok_path[PATH_W-1]};
                fwd_entry <= ins_lt ? own_q : tok_entry;
                fwd_path  <= tok_path << 1;
            end
            if (state == ST_CMP_SIFT && sift_down && !IS_LEAF) begin
                fwd_op    <= OP_SIFT;
                fwd_addr  <= {tok_addr, m_sel};
                fwd_entry <= tok_entry;
                fwd_path  <= tok_path << 1;
            end
            if (ovf_evt) overflow_q <= 1'b1;
        end
    end

    assign out_op    = fwd_op;
    assign out_addr  = fwd_addr;
    assign out_entry = fwd_entry;
    assign out_path  = fwd_path;
    assign overflow  = overflow_q;

`ifdef PHEAP_LEVEL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ins  <= '0;
            stat_sift <= '0;
            stat_ovf  <= '0;
        end else begin
            if (accept && in_op == OP_INSERT && stat_ins != 16'hFFFF)
                stat_ins <= stat_ins + 16'd1;
            if (accept && in_op == OP_SIFT && stat_sift != 16'hFFFF)
                stat_sift <= stat_sift + 16'd1;
            if (ovf_evt && stat_ovf != 16'hFFFF)
                stat_ovf <= stat_ovf + 16'd1;
        end
    end
`endif

endmodule
